// File: rtl/uart_alu_host.sv
// Host-side sequencer for the UART ALU link: sends A, B, opcode as 8N1 frames and collects the one-byte reply.
// Define RESP_TIMEOUT_EN to abandon a transaction when no reply start bit arrives within TIMEOUT_BITS bit periods.
module uart_alu_host #(
    parameter int DATA_WIDTH   = 8,
    parameter int OP_WIDTH     = 6,
    parameter int CLKS_PER_BIT = 2604,
    parameter int GAP_BITS     = 3,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data_a,
    input  logic [DATA_WIDTH-1:0] i_data_b,
    input  logic [OP_WIDTH-1:0]   i_opcode,
    output logic                  o_tx,
    input  logic                  i_rx,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_result_valid,
    output logic                  o_frame_err,
    output logic                  o_timeout
);

    localparam int CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int DIDX_W  = $clog2(DATA_WIDTH + 1);
    localparam int GIDX_W  = $clog2(GAP_BITS + 1);
    localparam int IDX_W   = (DIDX_W > GIDX_W) ? DIDX_W : GIDX_W;

    localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] GAP_LAST  = IDX_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    typedef enum logic [3:0] {
        IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_GAP,
        RX_WAIT,
        RX_START,
        RX_DATA,
        RX_STOP
    } state_t;

    state_t                  state;
    logic [3*DATA_WIDTH-1:0] tx_buf;
    logic [1:0]              byte_cnt;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]   rx_shift;
    logic                    rx_meta;
    logic                    rx_sync;
    logic                    rx_prev;
    logic                    bit_end;

`ifdef RESP_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_BITS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_BITS - 1);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    assign bit_end = (cnt == BIT_END);

    // Two-flop synchroniser plus one history flop for falling-edge detection; idle level is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Bit-period counter free-runs and reloads at each boundary; state entries that need
    // a fresh period (acceptance, rx start detect) clear it explicitly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            o_tx           <= 1'b1;
            o_ready        <= 1'b1;
            o_result       <= '0;
            o_result_valid <= 1'b0;
            o_frame_err    <= 1'b0;
            tx_buf         <= '0;
            byte_cnt       <= '0;
            cnt            <= '0;
            idx            <= '0;
            rx_shift       <= '0;
`ifdef RESP_TIMEOUT_EN
            o_timeout      <= 1'b0;
            tmo_cnt        <= '0;
`endif
        end else begin
            o_result_valid <= 1'b0;
            o_frame_err    <= 1'b0;
`ifdef RESP_TIMEOUT_EN
            o_timeout      <= 1'b0;
`endif
            cnt <= bit_end ? '0 : cnt + CNT_W'(1);

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    o_ready <= 1'b1;
                    if (i_valid && o_ready) begin
                        tx_buf   <= {DATA_WIDTH'(i_opcode), i_data_b, i_data_a};
                        byte_cnt <= '0;
                        o_tx     <= 1'b0;
                        o_ready  <= 1'b0;
                        state    <= TX_START;
                    end
                end

                TX_START: begin
                    if (bit_end) begin
                        o_tx  <= tx_buf[0];
                        idx   <= '0;
                        state <= TX_DATA;
                    end
                end

                // Whole buffer shifts one place per bit, so the next byte lands at the bottom after DATA_WIDTH bits.
                TX_DATA: begin
                    if (bit_end) begin
                        tx_buf <= tx_buf >> 1;
                        if (idx == DATA_LAST) begin
                            o_tx  <= 1'b1;
                            state <= TX_STOP;
                        end else begin
                            o_tx <= tx_buf[1];
                            idx  <= idx + IDX_W'(1);
                        end
                    end
                end

                TX_STOP: begin
                    if (bit_end) begin
                        idx <= '0;
                        if (GAP_BITS > 0) begin
                            state <= TX_GAP;
                        end else if (byte_cnt == 2'd2) begin
                            state <= RX_WAIT;
`ifdef RESP_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                            o_tx     <= 1'b0;
                            state    <= TX_START;
                        end
                    end
                end

                TX_GAP: begin
                    if (bit_end) begin
                        if (idx == GAP_LAST) begin
                            idx <= '0;
                            if (byte_cnt == 2'd2) begin
                                state <= RX_WAIT;
`ifdef RESP_TIMEOUT_EN
                                tmo_cnt <= '0;
`endif
                            end else begin
                                byte_cnt <= byte_cnt + 2'd1;
                                o_tx     <= 1'b0;
                                state    <= TX_START;
                            end
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end

                RX_WAIT: begin
                    if (rx_prev && !rx_sync) begin
                        cnt   <= '0;
                        state <= RX_START;
                    end
`ifdef RESP_TIMEOUT_EN
                    else if (bit_end) begin
                        if (tmo_cnt == TMO_LAST) begin
                            o_timeout <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
`endif
                end

                // Half-period check rejects short glitches and aligns later samples to mid-bit.
                RX_START: begin
                    if (cnt == HALF_END) begin
                        cnt <= '0;
                        idx <= '0;
                        if (rx_sync) begin
                            state <= RX_WAIT;
`ifdef RESP_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                        end else begin
                            state <= RX_DATA;
                        end
                    end
                end

                RX_DATA: begin
                    if (bit_end) begin
                        rx_shift <= {rx_sync, rx_shift[DATA_WIDTH-1:1]};
                        if (idx == DATA_LAST) begin
                            state <= RX_STOP;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end

                RX_STOP: begin
                    if (bit_end) begin
                        o_result       <= rx_shift;
                        o_result_valid <= 1'b1;
                        o_frame_err    <= !rx_sync;
                        state          <= IDLE;
                    end
                end

                default: begin
                    o_tx  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef RESP_TIMEOUT_EN
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_alu_host.sv
// Self-checking bench for uart_alu_host: plays the ALU side of the serial link with random traffic.
// The transmit waveform is checked per bit period against framing built from the operand bytes.
module tb_uart_alu_host;

    localparam int CPB = 16;
    localparam int GAP = 3;
    localparam int DW  = 8;
    localparam int BITS_PER_FRAME = DW + 2 + GAP;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data_a;
    logic [DW-1:0] i_data_b;
    logic [5:0]    i_opcode;
    logic          o_tx;
    logic          i_rx;
    logic [DW-1:0] o_result;
    logic          o_result_valid;
    logic          o_frame_err;
    logic          o_timeout;

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] expResult = '0;

    uart_alu_host #(
        .DATA_WIDTH(DW),
        .OP_WIDTH(6),
        .CLKS_PER_BIT(CPB),
        .GAP_BITS(GAP),
        .TIMEOUT_BITS(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_data_a(i_data_a),
        .i_data_b(i_data_b),
        .i_opcode(i_opcode),
        .o_tx(o_tx),
        .i_rx(i_rx),
        .o_result(o_result),
        .o_result_valid(o_result_valid),
        .o_frame_err(o_frame_err),
        .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sendReply(input logic [DW-1:0] data, input logic stopBit, input bit glitch);
        if (glitch) begin
            i_rx = 1'b0;
            repeat (3) @(negedge clk);
            i_rx = 1'b1;
            repeat (24) @(negedge clk);
        end
        i_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            i_rx = data[i];
            repeat (CPB) @(negedge clk);
        end
        i_rx = stopBit;
        repeat (CPB) @(negedge clk);
        i_rx = 1'b1;
    endtask

    // One full transaction: request, three transmitted frames, then the reply (or silence).
    task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [5:0] op,
                                 input logic [DW-1:0] reply, input logic stopBit, input bit glitch,
                                 input bit pokeBusy, input bit noReply);
        logic [DW-1:0] frameBytes [3];
        logic [15:0]   win;
        logic          expBit;
        bit            readyLow;
        int            pulses;
        int            tmoCount;
        int            tmoAt;
        bit            grabNext;
        logic [DW-1:0] gotResult;
        logic          gotErr;
        logic          readyAtPulse;
        logic          validAfter;
        logic          readyAfter;

        frameBytes[0] = a;
        frameBytes[1] = b;
        frameBytes[2] = {2'b00, op};
        readyLow      = 1'b1;
        pulses        = 0;
        tmoCount      = 0;
        tmoAt         = -1;
        grabNext      = 1'b0;
        gotResult     = '0;
        gotErr        = 1'b0;
        readyAtPulse  = 1'b1;
        validAfter    = 1'b1;
        readyAfter    = 1'b0;

        @(negedge clk);
        checkOutput("ready_before_req", o_ready, 1);
        checkOutput("tx_idle_before_req", o_tx, 1);
        i_valid  = 1'b1;
        i_data_a = a;
        i_data_b = b;
        i_opcode = op;
        @(negedge clk);
        i_valid  = 1'b0;
        i_data_a = 8'($urandom);
        i_data_b = 8'($urandom);
        i_opcode = 6'($urandom);

        for (int f = 0; f < 3; f++) begin
            for (int p = 0; p < BITS_PER_FRAME; p++) begin
                for (int s = 0; s < CPB; s++) begin
                    win[s] = o_tx;
                    if (o_ready !== 1'b0) readyLow = 1'b0;
                    i_valid = pokeBusy && (f == 1) && (p == 2) && (s < 2);
                    @(negedge clk);
                end
                if (p == 0) expBit = 1'b0;
                else if (p <= DW) expBit = frameBytes[f][p-1];
                else expBit = 1'b1;
                checkOutput($sformatf("tx_frame%0d_bit%0d", f, p), win, expBit ? 16'hFFFF : 16'h0000);
            end
        end
        checkOutput("ready_low_during_tx", readyLow, 1);

        fork
            begin
                if (!noReply) sendReply(reply, stopBit, glitch);
            end
            begin
                for (int n = 0; n < 400; n++) begin
                    if (grabNext) begin
                        validAfter = o_result_valid;
                        readyAfter = o_ready;
                        grabNext   = 1'b0;
                    end
                    if (o_timeout) begin
                        tmoCount++;
                        if (tmoAt < 0) tmoAt = n;
                    end
                    if (o_result_valid) begin
                        pulses++;
                        if (pulses == 1) begin
                            gotResult    = o_result;
                            gotErr       = o_frame_err;
                            readyAtPulse = o_ready;
                            grabNext     = 1'b1;
                        end
                    end
                    @(negedge clk);
                end
            end
        join

        if (noReply) begin
            checkOutput("result_pulses", pulses, 0);
            checkOutput("timeout_pulses", tmoCount, 1);
            checkOutput("timeout_cycle", tmoAt, 4 * CPB);
        end else begin
            expResult = reply;
            checkOutput("result_pulses", pulses, 1);
            checkOutput("result_value", gotResult, reply);
            checkOutput("frame_err", gotErr, !stopBit);
            checkOutput("ready_at_pulse", readyAtPulse, 0);
            checkOutput("valid_one_cycle", validAfter, 0);
            checkOutput("ready_after_pulse", readyAfter, 1);
            checkOutput("timeout_pulses", tmoCount, 0);
        end
        checkOutput("result_held", o_result, expResult);
        checkOutput("ready_end", o_ready, 1);
    endtask

    task automatic resetMidTransfer(input logic [DW-1:0] a, input logic [5:0] op);
        @(negedge clk);
        i_valid  = 1'b1;
        i_data_a = a;
        i_data_b = 8'h00;
        i_opcode = op;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (269) @(negedge clk);
        checkOutput("tx_before_reset", o_tx, 0);
        checkOutput("ready_before_reset", o_ready, 0);
        #2 reset = 1'b0;
        #1;
        expResult = '0;
        checkOutput("tx_async_reset", o_tx, 1);
        checkOutput("ready_async_reset", o_ready, 1);
        checkOutput("result_async_reset", o_result, expResult);
        checkOutput("valid_async_reset", o_result_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("tx_after_reset", o_tx, 1);
    endtask

    initial begin
        reset    = 1'b0;
        i_valid  = 1'b0;
        i_data_a = '0;
        i_data_b = '0;
        i_opcode = '0;
        i_rx     = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", o_tx, 1);
        checkOutput("reset_ready", o_ready, 1);
        checkOutput("reset_result", o_result, 0);
        checkOutput("reset_valid", o_result_valid, 0);
        checkOutput("reset_frame_err", o_frame_err, 0);
        checkOutput("reset_timeout", o_timeout, 0);
        reset = 1'b1;
        @(negedge clk);

        applyStimulus(8'h0A, 8'h17, 6'h24, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'($urandom), 8'($urandom), 6'($urandom), 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'($urandom), 8'($urandom), 6'($urandom), 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        resetMidTransfer(8'($urandom), 6'($urandom));
        applyStimulus(8'($urandom), 8'($urandom), 6'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), 6'($urandom), 8'($urandom),
                          1'b1, 1'b0, i == 0, 1'b0);
        end
`ifdef RESP_TIMEOUT_EN
        applyStimulus(8'($urandom), 8'($urandom), 6'($urandom), 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
